// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the IF and MEM pipeline stages.
// Each access runs IDLE -> IF_ACC/MEM_ACC -> DONE, with a streak limit and an access timeout.
module mem_port_arbiter #(
    parameter int unsigned MEM_STREAK_MAX = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ack_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_sel_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        bus_ce_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_sel_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        stallreq_if_o,
    output logic        stallreq_mem_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {StIdle, StIfAcc, StMemAcc, StDone} state_t;

    state_t      state;
    logic [31:0] streak;
    logic [31:0] tcount;
    logic        pick_mem;
    logic        timeout_hit;

    always_comb begin
        // MEM wins contested arbitration until it has starved IF for MEM_STREAK_MAX grants
        pick_mem       = mem_req_i && !(if_req_i && (streak == MEM_STREAK_MAX));
        timeout_hit    = (TIMEOUT_CYCLES != 0) && ((tcount + 32'd1) == TIMEOUT_CYCLES);
        stallreq_if_o  = if_req_i & ~if_ack_o;
        stallreq_mem_o = mem_req_i & ~mem_ack_o;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            streak      <= '0;
            tcount      <= '0;
            bus_ce_o    <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_sel_o   <= '0;
            if_ack_o    <= 1'b0;
            mem_ack_o   <= 1'b0;
            if_data_o   <= '0;
            mem_rdata_o <= '0;
            bus_err_o   <= 1'b0;
        end else begin
            if_ack_o  <= 1'b0;
            mem_ack_o <= 1'b0;
            bus_err_o <= 1'b0;
            unique case (state)
                StIdle: begin
                    tcount <= '0;
                    if (pick_mem) begin
                        state       <= StMemAcc;
                        bus_ce_o    <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_addr_o  <= mem_addr_i;
                        bus_wdata_o <= mem_wdata_i;
                        bus_sel_o   <= mem_sel_i;
                        if (!if_req_i) begin
                            streak <= '0;
                        end else if (streak != MEM_STREAK_MAX) begin
                            streak <= streak + 32'd1;
                        end
                    end else if (if_req_i) begin
                        state       <= StIfAcc;
                        bus_ce_o    <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_addr_o  <= if_addr_i;
                        bus_wdata_o <= '0;
                        bus_sel_o   <= 4'b1111;
                        streak      <= '0;
                    end
                end
                StIfAcc, StMemAcc: begin
                    // A bus ack in the timeout cycle completes normally, without error
                    if (bus_ack_i || timeout_hit) begin
                        state     <= StDone;
                        bus_ce_o  <= 1'b0;
                        bus_we_o  <= 1'b0;
                        bus_err_o <= !bus_ack_i;
                        if (state == StIfAcc) begin
                            if_ack_o  <= 1'b1;
                            if_data_o <= bus_ack_i ? bus_rdata_i : 32'd0;
                        end else begin
                            mem_ack_o   <= 1'b1;
                            mem_rdata_o <= (bus_ack_i && !bus_we_o) ? bus_rdata_i : 32'd0;
                        end
                    end else begin
                        tcount <= tcount + 32'd1;
                    end
                end
                StDone: begin
                    state  <= StIdle;
                    tcount <= '0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a round-based arbitration model predicts
// each grant, its bus fields, completion cycle and returned data; a monitor checks them.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_data_o;
    logic        if_ack_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [3:0]  mem_sel_i = '0;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        bus_ce_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_ack_i = 1'b0;
    logic        stallreq_if_o;
    logic        stallreq_mem_o;
    logic        bus_err_o;

    mem_port_arbiter #(
        .MEM_STREAK_MAX(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_i      (if_req_i),
        .if_addr_i     (if_addr_i),
        .if_data_o     (if_data_o),
        .if_ack_o      (if_ack_o),
        .mem_req_i     (mem_req_i),
        .mem_we_i      (mem_we_i),
        .mem_addr_i    (mem_addr_i),
        .mem_wdata_i   (mem_wdata_i),
        .mem_sel_i     (mem_sel_i),
        .mem_rdata_o   (mem_rdata_o),
        .mem_ack_o     (mem_ack_o),
        .bus_ce_o      (bus_ce_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_sel_o     (bus_sel_o),
        .bus_rdata_i   (bus_rdata_i),
        .bus_ack_i     (bus_ack_i),
        .stallreq_if_o (stallreq_if_o),
        .stallreq_mem_o(stallreq_mem_o),
        .bus_err_o     (bus_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          is_if;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] data;
        bit          err;
        int          rise_cyc;
        int          ce_cycles;
    } exp_t;

    exp_t exp_q[$];

    int          cfg_w = 0;
    logic [31:0] cfg_rd = '0;
    bit          pend_if = 1'b0;
    bit          pend_mem = 1'b0;
    int          streak_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Bus slave: acks in the (W+1)th cycle of chip enable, junk data otherwise
    int rk = 0;
    always @(negedge clk) begin
        if (rst || !bus_ce_o) begin
            rk = 0;
            bus_ack_i = 1'b0;
        end else begin
            rk++;
            if (rk == cfg_w + 1) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = cfg_rd;
            end else begin
                bus_ack_i   = 1'b0;
                bus_rdata_i = $urandom;
            end
        end
    end

    // Monitor: checks grants at chip-enable rise and completions at each ack
    bit prev_ce = 1'b0;
    int ce_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_ce = 1'b0;
            ce_cnt  = 0;
        end else begin
            chk("stall_if", 32'(stallreq_if_o), 32'(if_req_i & ~if_ack_o));
            chk("stall_mem", 32'(stallreq_mem_o), 32'(mem_req_i & ~mem_ack_o));
            chk("ack_exclusive", 32'(if_ack_o & mem_ack_o), 32'd0);
            chk("err_needs_ack", 32'(bus_err_o & ~(if_ack_o | mem_ack_o)), 32'd0);
            if (bus_ce_o && !prev_ce) begin
                if (exp_q.size() == 0) begin
                    chk("grant_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q[0];
                    chk("grant_we", 32'(bus_we_o), 32'(e.we));
                    chk("grant_addr", bus_addr_o, e.addr);
                    chk("grant_sel", 32'(bus_sel_o), 32'(e.sel));
                    if (!e.is_if) chk("grant_wdata", bus_wdata_o, e.wdata);
                    chk("grant_cycle", cyc, e.rise_cyc);
                end
            end
            if (bus_ce_o) ce_cnt++;
            prev_ce = bus_ce_o;
            if (if_ack_o || mem_ack_o) begin
                if (exp_q.size() == 0) begin
                    chk("ack_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_side_if", 32'(if_ack_o), 32'(e.is_if));
                    chk("ack_data", if_ack_o ? if_data_o : mem_rdata_o, e.data);
                    chk("ack_err", 32'(bus_err_o), 32'(e.err));
                    chk("ack_cycle", cyc, e.rise_cyc + e.ce_cycles);
                    chk("ce_cycles", ce_cnt, e.ce_cycles);
                end
                ce_cnt = 0;
            end
        end
    end

    task automatic issue(input bit new_if, input bit new_mem, input logic [31:0] ia,
                         input logic [31:0] ma, input bit mwe, input logic [31:0] mwd,
                         input logic [3:0] msel);
        if (new_if && !pend_if) begin
            pend_if   = 1'b1;
            if_req_i  = 1'b1;
            if_addr_i = ia;
        end
        if (new_mem && !pend_mem) begin
            pend_mem    = 1'b1;
            mem_req_i   = 1'b1;
            mem_we_i    = mwe;
            mem_addr_i  = ma;
            mem_wdata_i = mwd;
            mem_sel_i   = msel;
        end
    endtask

    // Model: one grant per round, made at the next edge; W >= 16 wait cycles means timeout
    task automatic grant(input int w, input logic [31:0] rd, output bit win_if);
        exp_t e;
        if (pend_if && pend_mem) begin
            win_if   = (streak_m == 4);
            streak_m = win_if ? 0 : streak_m + 1;
        end else begin
            win_if   = pend_if;
            streak_m = 0;
        end
        e.is_if     = win_if;
        e.we        = win_if ? 1'b0 : mem_we_i;
        e.addr      = win_if ? if_addr_i : mem_addr_i;
        e.wdata     = mem_wdata_i;
        e.sel       = win_if ? 4'b1111 : mem_sel_i;
        e.err       = (w >= 16);
        e.ce_cycles = (w >= 16) ? 16 : w + 1;
        e.data      = (e.err || e.we) ? 32'd0 : rd;
        e.rise_cyc  = cyc + 1;
        cfg_w  = w;
        cfg_rd = rd;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input bit win_if);
        int n;
        for (n = 0; n < 60; n++) begin
            @(negedge clk);
            if (win_if ? if_ack_o : mem_ack_o) break;
        end
        if (n >= 60) begin
            checks++;
            failures++;
            $display("FAIL ack_wait: no ack within 60 cycles, required ack (if=%0d)", win_if);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
        @(posedge clk);
        #1;
        if (win_if) begin
            pend_if  = 1'b0;
            if_req_i = 1'b0;
        end else begin
            pend_mem  = 1'b0;
            mem_req_i = 1'b0;
        end
    endtask

    task automatic round(input int w, input logic [31:0] rd);
        bit win;
        grant(w, rd, win);
        wait_ack(win);
    endtask

    task automatic rand_round();
        bit ni;
        bit nm;
        int r;
        int w;
        ni = 1'($urandom);
        nm = 1'($urandom);
        if (!pend_if && !pend_mem && !ni) nm = 1'b1;
        issue(ni, nm, $urandom & 32'h0000_fffc, 32'h1000_0000 | ($urandom & 32'hfffc),
              1'($urandom), $urandom, 4'($urandom));
        r = int'($urandom % 10);
        w = (r < 7) ? int'($urandom % 4) : (r == 7) ? 15 : (r == 8) ? 16 : 40;
        round(w, $urandom);
    endtask

    initial begin
        bit win;
        #2;
        chk("rst_ce", 32'(bus_ce_o), 32'd0);
        chk("rst_we", 32'(bus_we_o), 32'd0);
        chk("rst_addr", bus_addr_o, 32'd0);
        chk("rst_wdata", bus_wdata_o, 32'd0);
        chk("rst_sel", 32'(bus_sel_o), 32'd0);
        chk("rst_if_ack", 32'(if_ack_o), 32'd0);
        chk("rst_mem_ack", 32'(mem_ack_o), 32'd0);
        chk("rst_if_data", if_data_o, 32'd0);
        chk("rst_mem_rdata", mem_rdata_o, 32'd0);
        chk("rst_err", 32'(bus_err_o), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // IF-only zero-wait fetch
        issue(1'b1, 1'b0, 32'h0000_0004, '0, 1'b0, '0, '0);
        round(0, 32'h3401_1234);

        // Contested: store wins first, then the waiting fetch
        issue(1'b1, 1'b1, 32'h0000_0008, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        round(1, $urandom);
        round(0, $urandom);

        // Back-to-back MEM with IF held: M,M,M,M,I,M
        for (int i = 0; i < 6; i++) begin
            issue(1'b1, 1'b1, 32'h10 + 32'(4 * i), 32'h200 + 32'(4 * i), 1'b0, '0, 4'hf);
            round(i % 3, $urandom);
        end
        round(0, $urandom);

        // Timeout abort, then ack coinciding with the timeout cycle
        issue(1'b0, 1'b1, '0, 32'h0000_0300, 1'b0, '0, 4'hf);
        round(40, $urandom);
        issue(1'b0, 1'b1, '0, 32'h0000_0304, 1'b0, '0, 4'hf);
        round(15, 32'hCAFE_F00D);

        for (int i = 0; i < 250; i++) rand_round();
        while (pend_if || pend_mem) round(1, $urandom);

        // Reset during a stalled MEM access, with a fetch pending across the reset
        issue(1'b0, 1'b1, '0, 32'h0000_0400, 1'b0, '0, 4'hf);
        grant(40, $urandom, win);
        repeat (5) @(negedge clk);
        chk("ce_before_rst", 32'(bus_ce_o), 32'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_async_ce", 32'(bus_ce_o), 32'd0);
        chk("rst_async_mem_ack", 32'(mem_ack_o), 32'd0);
        exp_q.delete();
        mem_req_i = 1'b0;
        pend_mem  = 1'b0;
        streak_m  = 0;
        issue(1'b1, 1'b0, 32'h0000_0500, '0, 1'b0, '0, '0);
        @(posedge clk);
        #3 rst = 1'b0;
        round(0, 32'h1234_5678);

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the IF stage (instruction fetch) and the MEM stage (load/store) of the ToruMIPS pipeline.
- Sequences each access through a small FSM.
- Returns read data and a one-cycle ack to the winning requester.
- Raises per-stage stall requests to the pipeline control block while an access is outstanding.

Parameters:
- MEM_STREAK_MAX, 4: consecutive MEM grants allowed while IF is waiting; after this many, IF wins the next contested arbitration.
- TIMEOUT_CYCLES, 16: cycles in an access state without bus_ack_i before the access is aborted; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch request; held with if_addr_i until if_ack_o
- if_addr_i  in  32  fetch address
- if_data_o  out  32  fetched instruction, valid when if_ack_o=1
- if_ack_o  out  1  one-cycle completion pulse to IF
- mem_req_i  in  1  load/store request; held with address/data/we/sel until mem_ack_o
- mem_we_i  in  1  1 = store, 0 = load
- mem_addr_i  in  32  data address
- mem_wdata_i  in  32  store data
- mem_sel_i  in  4  byte enables
- mem_rdata_o  out  32  load data, valid when mem_ack_o=1
- mem_ack_o  out  1  one-cycle completion pulse to MEM
- bus_ce_o  out  1  external port chip enable
- bus_we_o  out  1  external write enable
- bus_addr_o  out  32  external address
- bus_wdata_o  out  32  external write data
- bus_sel_o  out  4  external byte enables
- bus_rdata_i  in  32  external read data
- bus_ack_i  in  1  external completion; sampled only while bus_ce_o=1
- stallreq_if_o  out  1  if_req_i & ~if_ack_o (combinational)
- stallreq_mem_o  out  1  mem_req_i & ~mem_ack_o (combinational)
- bus_err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: clock and reset as already decided (one clock `clk`; `rst` asynchronous, active-high). On rst=1, immediately:
  - state=IDLE; streak and timeout counters=0.
  - All registered outputs 0: bus_ce_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o, if_ack_o, mem_ack_o, if_data_o, mem_rdata_o, bus_err_o.
  - An in-flight access is dropped without an ack.
- States: IDLE, IF_ACC, MEM_ACC, DONE.
- IDLE transitions:
  - Only mem_req_i: go to MEM_ACC.
  - Only if_req_i: go to IF_ACC.
  - Both: MEM_ACC, unless streak==MEM_STREAK_MAX, then IF_ACC.
  - Neither: stay in IDLE.
  - The winner's address, wdata, we and sel are registered onto the bus_* outputs at the same edge. IF accesses drive we=0 and sel=4'b1111.
- Streak counter:
  - Increments on a MEM grant made while if_req_i=1.
  - Clears on any IF grant, or on a MEM grant made while if_req_i=0.
  - Saturates at MEM_STREAK_MAX.
- IF_ACC / MEM_ACC:
  - bus_ce_o=1; the timeout counter increments each cycle.
  - On bus_ack_i=1: capture bus_rdata_i into if_data_o or mem_rdata_o (stores capture 0), pulse the matching ack for one cycle, drop bus_ce_o and bus_we_o, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES (nonzero) without bus_ack_i: pulse the ack plus bus_err_o, data=0, go to DONE.
  - If bus_ack_i and the timeout coincide, bus_ack_i wins and there is no error.
- DONE:
  - Lasts exactly one cycle, during which the ack is high.
  - Requests are ignored, so a req still high in the ack cycle is not re-granted.
  - Next state is IDLE; the counter clears.
- Latency:
  - Requester must drop req, or present a new request, by the cycle after its ack.
  - With a zero-wait bus (bus_ack_i high in the first ce cycle): req at cycle 0, bus_ce_o cycle 1, ack cycle 2, next grant edge at end of cycle 3.
  - A wait of W bus cycles adds W cycles.
- Only one of if_ack_o / mem_ack_o is ever high in a given cycle.
- Requests deasserted mid-access are protocol violations; the access still completes.
- bus_rdata_i is ignored outside ACC states.

Test Plan:
- Reset during MEM_ACC (bus stalled) → bus_ce_o falls asynchronously; no mem_ack_o; after release, IDLE and the pending if_req_i is granted.
- IF-only fetch 0x00000004, zero-wait bus returning 0x34011234 → bus_ce_o cycle 1, if_ack_o cycle 2 with if_data_o=0x34011234, stallreq_if_o high cycles 0-1.
- if_req_i and mem_req_i both high, store 0xDEADBEEF to 0x100 sel=4'b0011 → MEM granted first (bus_we_o=1, bus_sel_o=4'b0011); IF granted on the next IDLE.
- mem_req_i re-asserted back-to-back for 6 accesses with if_req_i held → grants M,M,M,M,I,M (MEM_STREAK_MAX=4).
- bus_ack_i never asserted on a load → after 16 ACC cycles, mem_ack_o and bus_err_o pulse together, mem_rdata_o=0, state returns to IDLE.
- Requester holds req through its ack cycle → no second grant in DONE; grant occurs only if req is still high in IDLE.
